// File: rtl/alct_sc_test.sv
// Single-cable loopback test engine: drives a 48-step pattern on pat_out, compares the
// looped-back cable against an LAT-delayed copy and accumulates word/bit error results.
module alct_sc_test #(
  parameter int N   = 7,
  parameter int LAT = 1
) (
  input  logic            clock_mez,
  input  logic            reset,
  input  logic [N*48-1:0] lct_n,
  input  logic [2:0]      cable_sel,
  input  logic [1:0]      m_seq_cmd,
  input  logic            start,
  output logic [47:0]     pat_out,
  output logic [15:0]     err_cnt,
  output logic [47:0]     err_bits,
  output logic [1:0]      m_seq_status,
  output logic [N-1:0]    feb_grn
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [2:0]    cable_q, cable_d;
  logic [5:0]    step_q, step_d;
  logic [47:0]   pat_q, pat_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [47:0]   err_bits_q, err_bits_d;
  logic [1:0]    status_q, status_d;
  logic [N-1:0]  feb_q, feb_d;
  logic [47:0]   rx_q, rx_sel;
  logic [47:0]   exp_q [LAT];
  logic [47:0]   exp_last;
  logic          start_ok, compare_en, mismatch, pass;

  function automatic logic [47:0] pattern(input logic [1:0] mode, input logic [5:0] step);
    case (mode)
      2'd1:    pattern = 48'd1 << step;
      2'd2:    pattern = ~(48'd1 << step);
      2'd3:    pattern = step[0] ? 48'h5555_5555_5555 : 48'hAAAA_AAAA_AAAA;
      default: pattern = '0;
    endcase
  endfunction

  always_comb begin
    rx_sel = '0;
    for (int c = 0; c < N; c++) begin
      if (cable_q == 3'(c)) rx_sel = ~lct_n[c*48 +: 48];
    end
  end

  assign exp_last   = exp_q[LAT-1];
  assign start_ok   = start && (m_seq_cmd != 2'd0) && (32'(cable_sel) < N);
  // Compare window covers exactly the 48 words once they emerge from the loopback.
  assign compare_en = (state_q == RUN) && (step_q >= 6'(LAT)) && (step_q <= 6'(47 + LAT));
  assign mismatch   = compare_en && (rx_q != exp_last);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cable_d    = cable_q;
    step_d     = step_q;
    pat_d      = pat_q;
    err_cnt_d  = err_cnt_q;
    err_bits_d = err_bits_q;
    status_d   = status_q;
    feb_d      = feb_q;
    pass       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d    = RUN;
          mode_d     = m_seq_cmd;
          cable_d    = cable_sel;
          step_d     = '0;
          pat_d      = pattern(m_seq_cmd, 6'd0);
          err_cnt_d  = '0;
          err_bits_d = '0;
          status_d   = '0;
        end
      end
      RUN: begin
        step_d = step_q + 6'd1;
        pat_d  = (step_d <= 6'd47) ? pattern(mode_q, step_d) : '0;
        if (mismatch) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          err_bits_d = err_bits_q | (rx_q ^ exp_last);
        end
        if (step_q == 6'(47 + LAT)) begin
          pass     = (err_cnt_d == 16'd0);
          state_d  = DONE;
          status_d = {pass, 1'b1};
          for (int c = 0; c < N; c++) begin
            if (cable_q == 3'(c)) feb_d[c] = pass;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_mez or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      cable_q    <= '0;
      step_q     <= '0;
      pat_q      <= '0;
      err_cnt_q  <= '0;
      err_bits_q <= '0;
      status_q   <= '0;
      feb_q      <= '0;
      rx_q       <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cable_q    <= cable_d;
      step_q     <= step_d;
      pat_q      <= pat_d;
      err_cnt_q  <= err_cnt_d;
      err_bits_q <= err_bits_d;
      status_q   <= status_d;
      feb_q      <= feb_d;
      rx_q       <= rx_sel;
    end
  end

  // Expected-word delay line mirrors the loopback latency of pat_out into rx_q.
  always_ff @(posedge clock_mez or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) exp_q[i] <= '0;
    end else begin
      exp_q[0] <= pat_q;
      for (int i = 1; i < LAT; i++) exp_q[i] <= exp_q[i-1];
    end
  end

  assign pat_out      = pat_q;
  assign err_cnt      = err_cnt_q;
  assign err_bits     = err_bits_q;
  assign m_seq_status = status_q;
  assign feb_grn      = feb_q;

endmodule

// File: tb/tb_alct_sc_test.sv
// Directed bench for alct_sc_test: a LAT=1 instance with a configurable faulty loopback
// and a LAT=3 instance with open-cable or two-cycle-delayed loopback.
`timescale 1ns/1ps
module tb_alct_sc_test;
  localparam int N = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      cable_sel;
  logic [1:0]      cmd;
  logic            start1, start3;
  logic [N*48-1:0] lct1, lct3;
  logic [47:0]     pat1, pat3, bits1, bits3;
  logic [15:0]     cnt1, cnt3;
  logic [1:0]      st1, st3;
  logic [N-1:0]    feb1, feb3;

  // Loopback fault controls: s0/s1 force lct_n lines low/high on the looped cable.
  int              lb_cable1;
  logic [47:0]     s0_mask, s1_mask;
  logic            lb3_en;
  logic [47:0]     d1, d2;
  logic            use3;
  logic [47:0]     pat_s, bits_s;
  logic [15:0]     cnt_s;
  logic [1:0]      st_s;
  logic [N-1:0]    feb_s;

  typedef struct packed {
    logic [15:0]  cnt;
    logic [47:0]  bits;
    logic [1:0]   st;
    logic [N-1:0] feb;
  } res_t;

  logic [47:0] pat_q[$];
  res_t        res_q[$];
  logic [N-1:0] feb_exp1, feb_exp3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alct_sc_test #(.N(N), .LAT(1)) u_dut1 (
    .clock_mez(clk), .reset(reset), .lct_n(lct1), .cable_sel(cable_sel),
    .m_seq_cmd(cmd), .start(start1), .pat_out(pat1), .err_cnt(cnt1),
    .err_bits(bits1), .m_seq_status(st1), .feb_grn(feb1)
  );

  alct_sc_test #(.N(N), .LAT(3)) u_dut3 (
    .clock_mez(clk), .reset(reset), .lct_n(lct3), .cable_sel(cable_sel),
    .m_seq_cmd(cmd), .start(start3), .pat_out(pat3), .err_cnt(cnt3),
    .err_bits(bits3), .m_seq_status(st3), .feb_grn(feb3)
  );

  always_comb begin
    lct1 = '1;
    for (int c = 0; c < N; c++) begin
      if (c == lb_cable1) lct1[c*48 +: 48] = (~pat1 & ~s0_mask) | s1_mask;
    end
  end

  always @(posedge clk) begin
    d1 <= pat3;
    d2 <= d1;
  end
  assign lct3 = lb3_en ? {{((N-1)*48){1'b1}}, ~d2} : '1;

  assign pat_s  = use3 ? pat3  : pat1;
  assign bits_s = use3 ? bits3 : bits1;
  assign cnt_s  = use3 ? cnt3  : cnt1;
  assign st_s   = use3 ? st3   : st1;
  assign feb_s  = use3 ? feb3  : feb1;

  function automatic logic [47:0] exp_pat(input logic [1:0] m, input int s);
    case (m)
      2'd1:    return 48'd1 << s;
      2'd2:    return ~(48'd1 << s);
      2'd3:    return (s % 2 == 1) ? 48'h5555_5555_5555 : 48'hAAAA_AAAA_AAAA;
      default: return 48'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run(input bit sel3, input logic [1:0] mode, input int cab,
                     input bit open, input bit glitch);
    logic [47:0] p, rx, ebits;
    int          ecnt, cyc, lat;
    res_t        r;
    ecnt  = 0;
    ebits = '0;
    lat   = sel3 ? 3 : 1;
    for (int s = 0; s < 48; s++) begin
      p = exp_pat(mode, s);
      pat_q.push_back(p);
      if (open || (!sel3 && cab != lb_cable1)) rx = '0;
      else if (sel3) rx = p;
      else rx = (p | s0_mask) & ~s1_mask;
      if (rx != p) begin
        ecnt++;
        ebits |= rx ^ p;
      end
    end
    if (sel3) feb_exp3[cab] = (ecnt == 0);
    else      feb_exp1[cab] = (ecnt == 0);
    r.cnt  = 16'(ecnt);
    r.bits = ebits;
    r.st   = {(ecnt == 0), 1'b1};
    r.feb  = sel3 ? feb_exp3 : feb_exp1;
    res_q.push_back(r);

    @(negedge clk);
    use3      = sel3;
    cmd       = mode;
    cable_sel = 3'(cab);
    if (sel3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 0) begin start1 = 1'b0; start3 = 1'b0; end
      if (glitch && k == 10) begin
        cmd = 2'd3;
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
      end
      if (glitch && k == 11) begin
        cmd = mode; start1 = 1'b0; start3 = 1'b0;
      end
      check($sformatf("pat_step%0d", k), 64'(pat_s), 64'(pat_q.pop_front()));
    end
    @(negedge clk);
    cyc = 48;
    check("pat_after_47", 64'(pat_s), 64'(0));
    while (!st_s[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("done_cycle", 64'(cyc), 64'(48 + lat));
    r = res_q.pop_front();
    check("err_cnt",  64'(cnt_s),  64'(r.cnt));
    check("err_bits", 64'(bits_s), 64'(r.bits));
    check("status",   64'(st_s),   64'(r.st));
    check("feb_grn",  64'(feb_s),  64'(r.feb));
    $display("run lat=%0d mode=%0d cable=%0d err_cnt=%0d err_bits=%h status=%b feb=%b",
             lat, mode, cab, cnt_s, bits_s, st_s, feb_s);
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; cmd = 2'd0; cable_sel = 3'd0;
    lb_cable1 = 0; s0_mask = '0; s1_mask = '0; lb3_en = 1'b0; use3 = 1'b0;
    feb_exp1 = '0; feb_exp3 = '0;
    repeat (3) @(negedge clk);
    check("rst_pat",    64'(pat1),  64'(0));
    check("rst_cnt",    64'(cnt1),  64'(0));
    check("rst_bits",   64'(bits1), 64'(0));
    check("rst_status", 64'(st1),   64'(0));
    check("rst_feb",    64'(feb1),  64'(0));
    reset = 1'b0;

    // Rejected starts: cable_sel == N, then m_seq_cmd == 0
    @(negedge clk); cmd = 2'd1; cable_sel = 3'd7; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rej_cable_pat",    64'(pat1), 64'(0));
    check("rej_cable_status", 64'(st1),  64'(0));
    @(negedge clk); cmd = 2'd0; cable_sel = 3'd0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rej_cmd_pat",    64'(pat1), 64'(0));
    check("rej_cmd_status", 64'(st1),  64'(0));
    check("rej_cmd_feb",    64'(feb1), 64'(0));
    $display("rejected starts: pat=%h status=%b", pat1, st1);

    // Walking zero with lct_n bit 5 stuck low on cable 0
    s0_mask = 48'h20;
    run(1'b0, 2'd2, 0, 1'b0, 1'b0);
    // Clean walking one on cable 0, with a start pulse mid-run that must be ignored
    s0_mask = '0;
    run(1'b0, 2'd1, 0, 1'b0, 1'b1);
    // Alternating on cable 3 with lct_n bit 0 stuck high
    lb_cable1 = 3; s1_mask = 48'h1;
    run(1'b0, 2'd3, 3, 1'b0, 1'b0);
    // Highest legal cable
    lb_cable1 = 6; s1_mask = '0;
    run(1'b0, 2'd2, 6, 1'b0, 1'b0);

    // Reset at step 20 of a mode-1 run
    lb_cable1 = 0;
    @(negedge clk); use3 = 1'b0; cmd = 2'd1; cable_sel = 3'd0; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start1 = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_pat", 64'(pat1), 64'(48'd1 << 20));
    reset = 1'b1;
    #1;
    check("abort_pat",    64'(pat1), 64'(0));
    check("abort_status", 64'(st1),  64'(0));
    check("abort_cnt",    64'(cnt1), 64'(0));
    check("abort_feb",    64'(feb1), 64'(0));
    $display("reset mid-run: pat=%h status=%b feb=%b", pat1, st1, feb1);
    feb_exp1 = '0; feb_exp3 = '0;
    @(negedge clk); reset = 1'b0;
    run(1'b0, 2'd1, 0, 1'b0, 1'b0);

    // LAT=3 instance: open cable, then delayed loopback
    lb3_en = 1'b0;
    run(1'b1, 2'd1, 0, 1'b1, 1'b0);
    lb3_en = 1'b1;
    run(1'b1, 2'd1, 0, 1'b0, 1'b0);
    run(1'b1, 2'd3, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alct_sc_test.md
Name:
alct_sc_test

Overview:
- Single-cable test engine for the ALCT mezzanine.
- Emits a 48-bit test pattern sequence on pat_out, which the tester loops back onto one of the N LCT input cables.
- Compares the looped-back word against the delayed expected pattern and accumulates a word error count and a bit-error map.
- Reports status to the sequencer (m_seq_status) and to per-cable FEB LEDs.

Parameters:
- N, 7, number of 48-bit LCT cables (7 for ALCT672, 4 for ALCT384, 3 for ALCT288).
- LAT, 1, cycles from a pat_out update to the matching word appearing in rx_q. Legal range 1..8.

Ports:
- clock_mez  in  1  40 MHz mezzanine clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- lct_n  in  N*48  LCT cables, active low; cable c occupies bits [48c+47:48c].
- cable_sel  in  3  cable under test; sampled on start.
- m_seq_cmd  in  2  pattern mode: 0 = none, 1 = walking one, 2 = walking zero, 3 = alternating; sampled on start.
- start  in  1  single-cycle start pulse.
- pat_out  out  48  pattern driven toward the tester, active high.
- err_cnt  out  16  count of mismatched words; saturates at 16'hFFFF.
- err_bits  out  48  OR-accumulated mismatching bit positions.
- m_seq_status  out  2  {pass, done}.
- feb_grn  out  N  per-cable pass LED.

Behaviour:
- Reset values: every output and every internal register is 0; the FSM is in IDLE.
- FSM states: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE only when m_seq_cmd != 0 and cable_sel < N. Otherwise start is ignored and the state is unchanged.
  - start is ignored while in RUN.
- On an accepted start (edge 0):
  - latch the mode and the cable; clear err_cnt, err_bits and m_seq_status; set step = 0; enter RUN.
- In RUN:
  - step increments 0..47+LAT, one per cycle.
  - For step 0..47, pat_out is registered with the pattern for that step:
    - mode 1: 48'b1 << step.
    - mode 2: ~(48'b1 << step).
    - mode 3: 48'hAAAA_AAAA_AAAA when step is even, 48'h5555_5555_5555 when step is odd.
  - pat_out returns to 0 after step 47.
- Receive and compare:
  - Every cycle, rx_q is registered as ~lct_n[selected cable].
  - Expected words pass through an LAT-deep pipeline of pat_out.
  - Compare is active only when LAT <= step <= 47+LAT, giving exactly 48 compares.
  - On a compare cycle where rx_q != expected: err_cnt increments (saturating) and err_bits |= rx_q ^ expected.
- Completion:
  - After the compare at step 47+LAT the FSM enters DONE.
  - m_seq_status becomes {err_cnt_final == 0, 1}, including a mismatch on that final compare.
  - feb_grn[cable] is set to the pass value; other feb_grn bits hold.
- DONE holds all results until the next accepted start or reset.
- Reset asserted mid-run aborts the run immediately: IDLE state, all outputs 0, feb_grn cleared.
- Zero-delay external loopback (lct_n = ~pat_out) requires LAT = 1.

Test Plan:
- Loopback lct_n[cable 0] = ~pat_out, LAT=1, mode 1, start -> pat_out = 1,2,4,..., bit 47; after 49 cycles m_seq_status = 2'b11, err_cnt = 0, feb_grn[0] = 1.
- Same loopback, bit 5 of cable 0 stuck at 0, mode 2 -> err_cnt = 1, err_bits = 48'h20, m_seq_status = 2'b01, feb_grn[0] = 0.
- Cable 3 loopback with bit 0 stuck at 1, mode 3 -> err_cnt = 24 (odd steps), err_bits = 48'h1, other feb_grn bits unchanged.
- Rejected starts: start with cable_sel = 7 (N = 7) or with m_seq_cmd = 0 -> state stays IDLE, all outputs 0.
- Reset at step 20 of a mode 1 run -> pat_out = 0, m_seq_status = 0, err_cnt = 0, feb_grn = 0; a new start then runs a clean pass.
- Open-cable saturation: N = 7, LAT = 3, lct_n all ones (rx = 0), mode 1 -> 48 errors, err_bits = all ones; pipeline alignment checked via a delayed-loopback bench giving err_cnt = 0.
